// File: rtl/chase_steer.sv
// chase_steer: once-per-frame steering controller for the chase robot.
// Samples the tracker centroid/radius on the falling edge of vsync, smooths
// the horizontal position, runs the search/track/close machine and drives
// two 8-bit PWM wheel channels with direction bits.
//
//   state  | meaning
//   -------+------------------------------------------------------
//   IDLE   | motors off, waiting for enable and a frame strobe
//   SEARCH | no target, spin clockwise in place
//   TRACK  | target visible, drive forward with differential steer
//   CLOSE  | target near, stop until it backs off past hysteresis
module chase_steer #(
    parameter int unsigned CENTER_X    = 512,
    parameter int unsigned DEADBAND    = 32,
    parameter int unsigned R_MIN       = 4,
    parameter int unsigned R_NEAR      = 120,
    parameter int unsigned R_HYST      = 16,
    parameter int unsigned LOST_FRAMES = 8,
    parameter int unsigned BASE_DUTY   = 160,
    parameter int unsigned SPIN_DUTY   = 96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        vsync,
    input  logic [31:0] x_center,
    input  logic [23:0] radius,
    output logic        left_pwm,
    output logic        right_pwm,
    output logic        left_dir,
    output logic        right_dir,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SEARCH = 2'b01,
        ST_TRACK  = 2'b10,
        ST_CLOSE  = 2'b11
    } state_t;

    localparam logic [9:0]  XF_RESET   = 10'(CENTER_X);
    localparam logic [10:0] CENTER_W   = 11'(CENTER_X);
    localparam logic [10:0] DEADBAND_W = 11'(DEADBAND);
    localparam logic [15:0] R_MIN_W    = 16'(R_MIN);
    localparam logic [15:0] R_NEAR_W   = 16'(R_NEAR);
    localparam logic [15:0] R_EXIT_W   = 16'(R_NEAR - R_HYST);
    localparam logic [3:0]  LOST_W     = 4'(LOST_FRAMES);
    localparam logic [7:0]  BASE_W     = 8'(BASE_DUTY);
    localparam logic [7:0]  SPIN_W     = 8'(SPIN_DUTY);

    logic        vsync_q, strobe, p1, p2;
    logic [9:0]  x_lat, x_f, x_avg;
    logic [15:0] r_lat;
    logic        hit;
    logic [3:0]  lost, lost_nx;
    logic        lost_out;
    state_t      st, st_nx;

    logic [10:0] err_u, mag;
    logic [8:0]  steer_raw, hi_sum;
    logic [7:0]  steer, hi_duty, lo_duty;
    logic [7:0]  l_duty_nx, r_duty_nx;
    logic        l_dir_nx, r_dir_nx;

    logic [7:0]  l_shadow, r_shadow, l_active, r_active, pwm_cnt;
    logic        l_dir_sh, r_dir_sh;

    assign strobe   = vsync_q & ~vsync;
    assign hit      = (r_lat >= R_MIN_W);
    assign x_avg    = 10'(({1'b0, x_f} + {1'b0, x_lat}) >> 1);
    assign lost_nx  = hit ? 4'd0 : ((lost == 4'hF) ? lost : lost + 4'd1);
    assign lost_out = (lost_nx >= LOST_W);
    assign state    = st;

    // Signed error from straight ahead, its magnitude and the clamped steer term.
    assign err_u     = {1'b0, x_f} - CENTER_W;
    assign mag       = err_u[10] ? (~err_u + 11'd1) : err_u;
    assign steer_raw = mag[10:2];
    assign steer     = (steer_raw > {1'b0, BASE_W}) ? BASE_W : steer_raw[7:0];
    assign hi_sum    = {1'b0, BASE_W} + {1'b0, steer};
    assign hi_duty   = hi_sum[8] ? 8'hFF : hi_sum[7:0];
    assign lo_duty   = BASE_W - steer;

    // Frame strobe detection, latch stage and the S+1/S+2 pipeline tokens;
    // a second strobe mid-pipeline overwrites the latch and restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q <= 1'b0;
            p1      <= 1'b0;
            p2      <= 1'b0;
            x_lat   <= '0;
            r_lat   <= '0;
            x_f     <= XF_RESET;
            lost    <= '0;
        end else begin
            vsync_q <= vsync;
            p1      <= strobe;
            p2      <= p1 & ~strobe;
            if (strobe) begin
                x_lat <= (|x_center[31:10]) ? 10'h3FF : x_center[9:0];
                r_lat <= (|radius[23:16]) ? 16'hFFFF : radius[15:0];
            end
            if (p1 && !strobe && hit)
                x_f <= x_avg;
            if (p2)
                lost <= lost_nx;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            st <= ST_IDLE;
        else
            st <= st_nx;
    end

    // Next state: enable low wins immediately, otherwise move only at S+2.
    always_comb begin
        st_nx = st;
        if (!enable) begin
            st_nx = ST_IDLE;
        end else if (p2) begin
            case (st)
                ST_IDLE:   st_nx = ST_SEARCH;
                ST_SEARCH: if (hit) st_nx = ST_TRACK;
                ST_TRACK: begin
                    if (r_lat >= R_NEAR_W) st_nx = ST_CLOSE;
                    else if (lost_out)     st_nx = ST_SEARCH;
                end
                ST_CLOSE: begin
                    if (hit && (r_lat < R_EXIT_W)) st_nx = ST_TRACK;
                    else if (lost_out)             st_nx = ST_SEARCH;
                end
                default:   st_nx = ST_IDLE;
            endcase
        end
    end

    // Wheel duties and directions for the state being entered.
    always_comb begin
        l_duty_nx = 8'd0;
        r_duty_nx = 8'd0;
        l_dir_nx  = 1'b1;
        r_dir_nx  = 1'b1;
        case (st_nx)
            ST_SEARCH: begin
                l_duty_nx = SPIN_W;
                r_duty_nx = SPIN_W;
                r_dir_nx  = 1'b0;
            end
            ST_TRACK: begin
                if (mag <= DEADBAND_W) begin
                    l_duty_nx = BASE_W;
                    r_duty_nx = BASE_W;
                end else if (!err_u[10]) begin
                    l_duty_nx = hi_duty;
                    r_duty_nx = lo_duty;
                end else begin
                    l_duty_nx = lo_duty;
                    r_duty_nx = hi_duty;
                end
            end
            default: ;
        endcase
    end

    // Shadow duties load at S+2 and are cleared outright while disabled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            l_shadow <= '0;
            r_shadow <= '0;
            l_dir_sh <= 1'b0;
            r_dir_sh <= 1'b0;
        end else if (!enable) begin
            l_shadow <= '0;
            r_shadow <= '0;
        end else if (p2) begin
            l_shadow <= l_duty_nx;
            r_shadow <= r_duty_nx;
            l_dir_sh <= l_dir_nx;
            r_dir_sh <= r_dir_nx;
        end
    end

    // PWM generator: shadows become active at the 255->0 wrap so a period
    // is never cut short; disable kills the drive on the next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm_cnt   <= '0;
            l_active  <= '0;
            r_active  <= '0;
            left_dir  <= 1'b0;
            right_dir <= 1'b0;
            left_pwm  <= 1'b0;
            right_pwm <= 1'b0;
        end else begin
            pwm_cnt <= pwm_cnt + 8'd1;
            if (!enable) begin
                l_active  <= '0;
                r_active  <= '0;
                left_pwm  <= 1'b0;
                right_pwm <= 1'b0;
            end else begin
                if (pwm_cnt == 8'hFF) begin
                    l_active  <= l_shadow;
                    r_active  <= r_shadow;
                    left_dir  <= l_dir_sh;
                    right_dir <= r_dir_sh;
                end
                left_pwm  <= (pwm_cnt < l_active);
                right_pwm <= (pwm_cnt < r_active);
            end
        end
    end

endmodule

// File: tb/tb_chase_steer.sv
// Testbench for chase_steer: directed frame table, two hand-written corner
// sequences and random frames checked against a frame-level reference model.
module tb_chase_steer;

    logic        clk = 1'b0;
    logic        reset, enable, vsync;
    logic [31:0] x_center;
    logic [23:0] radius;
    logic        left_pwm, right_pwm, left_dir, right_dir;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;

    // Frame-level reference model
    int m_st, m_xf, m_lost;

    typedef struct {
        bit          en;
        logic [31:0] x;
        logic [23:0] r;
        int          st;
        int          l_duty;
        int          r_duty;
        int          l_dir;
        int          r_dir;
    } vec_t;

    vec_t tbl[$];

    chase_steer dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .vsync     (vsync),
        .x_center  (x_center),
        .radius    (radius),
        .left_pwm  (left_pwm),
        .right_pwm (right_pwm),
        .left_dir  (left_dir),
        .right_dir (right_dir),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_xf = 512; m_lost = 0;
    endtask

    // One frame of the controller seen from outside: latch, filter, lost, state.
    task automatic model_frame(input bit en, input logic [31:0] x, input logic [23:0] r);
        int xl, rl;
        bit hit;
        xl  = (x > 32'd1023) ? 1023 : int'(x);
        rl  = (r > 24'd65535) ? 65535 : int'(r);
        hit = (rl >= 4);
        if (hit) m_xf = (m_xf + xl) / 2;
        m_lost = hit ? 0 : ((m_lost < 15) ? m_lost + 1 : 15);
        if (!en) m_st = 0;
        else begin
            case (m_st)
                0: m_st = 1;
                1: if (hit) m_st = 2;
                2: if (rl >= 120) m_st = 3; else if (m_lost >= 8) m_st = 1;
                3: if (hit && rl < 104) m_st = 2; else if (m_lost >= 8) m_st = 1;
                default: m_st = 0;
            endcase
        end
    endtask

    task automatic model_duty(output int l, output int r, output int ld, output int rd);
        int e, mag, steer;
        e = m_xf - 512;
        mag = (e < 0) ? -e : e;
        steer = (mag / 4 > 160) ? 160 : mag / 4;
        l = 0; r = 0; ld = 1; rd = 1;
        if (m_st == 1) begin
            l = 96; r = 96; rd = 0;
        end else if (m_st == 2) begin
            if (mag <= 32) begin
                l = 160; r = 160;
            end else if (e > 0) begin
                l = (160 + steer > 255) ? 255 : 160 + steer; r = 160 - steer;
            end else begin
                r = (160 + steer > 255) ? 255 : 160 + steer; l = 160 - steer;
            end
        end
    endtask

    // Drive one frame, read state after the pipeline, then measure one full
    // PWM period after the new duty has surely been applied.
    task automatic run_frame(input bit en, input logic [31:0] x, input logic [23:0] r,
                             output int st, output int lc, output int rc,
                             output int ld, output int rd);
        @(posedge clk); #1;
        enable = en; x_center = x; radius = r; vsync = 1'b1;
        repeat (3) @(posedge clk);
        #1 vsync = 1'b0;
        repeat (4) @(posedge clk);
        #1 st = int'(state);
        repeat (258) @(posedge clk);
        lc = 0; rc = 0;
        for (int k = 0; k < 256; k++) begin
            @(posedge clk); #1;
            lc += int'(left_pwm);
            rc += int'(right_pwm);
        end
        ld = int'(left_dir);
        rd = int'(right_dir);
    endtask

    task automatic check_frame(input string tag, input int st, input int lc, input int rc,
                               input int ld, input int rd, input int e_st, input int e_l,
                               input int e_r, input int e_ld, input int e_rd);
        chk({tag, " state"}, st, e_st);
        chk({tag, " left_duty"}, lc, e_l);
        chk({tag, " right_duty"}, rc, e_r);
        if (e_st != 0) begin
            chk({tag, " left_dir"}, ld, e_ld);
            chk({tag, " right_dir"}, rd, e_rd);
        end
    endtask

    initial begin
        int st, lc, rc, ld, rd;
        int el, er, eld, erd;
        bit found;
        bit en;
        logic [31:0] x;
        logic [23:0] r;

        // Directed frames: reset/idle, spin, steer, close, lost, mirror, saturation, boundaries
        repeat (3) tbl.push_back('{1'b0, 32'd512, 24'd0, 0, 0, 0, 1, 1});
        repeat (2) tbl.push_back('{1'b1, 32'd512, 24'd0, 1, 96, 96, 1, 0});
        tbl.push_back('{1'b1, 32'd832, 24'd50, 2, 200, 120, 1, 1});
        tbl.push_back('{1'b1, 32'd832, 24'd50, 2, 220, 100, 1, 1});
        tbl.push_back('{1'b1, 32'd832, 24'd50, 2, 230, 90, 1, 1});
        tbl.push_back('{1'b1, 32'd832, 24'd50, 2, 235, 85, 1, 1});
        tbl.push_back('{1'b1, 32'd832, 24'd130, 3, 0, 0, 1, 1});
        tbl.push_back('{1'b1, 32'd832, 24'd110, 3, 0, 0, 1, 1});
        tbl.push_back('{1'b1, 32'd832, 24'd100, 2, 239, 81, 1, 1});
        repeat (7) tbl.push_back('{1'b1, 32'd200, 24'd0, 2, 239, 81, 1, 1});
        tbl.push_back('{1'b1, 32'd200, 24'd0, 1, 96, 96, 1, 0});
        tbl.push_back('{1'b1, 32'd192, 24'd20, 2, 160, 160, 1, 1});
        tbl.push_back('{1'b1, 32'd0, 24'd20, 2, 96, 224, 1, 1});
        tbl.push_back('{1'b1, 32'd0, 24'd20, 2, 64, 255, 1, 1});
        tbl.push_back('{1'b1, 32'hFFFF_FC00, 24'hFF_0000, 3, 0, 0, 1, 1});
        tbl.push_back('{1'b1, 32'hFFFF_FC00, 24'd4, 2, 231, 89, 1, 1});
        tbl.push_back('{1'b1, 32'd0, 24'd3, 2, 231, 89, 1, 1});
        tbl.push_back('{1'b1, 32'd799, 24'd120, 3, 0, 0, 1, 1});
        tbl.push_back('{1'b1, 32'd799, 24'd104, 3, 0, 0, 1, 1});
        tbl.push_back('{1'b1, 32'd799, 24'd103, 2, 231, 89, 1, 1});
        tbl.push_back('{1'b1, 32'd289, 24'd50, 2, 160, 160, 1, 1});
        tbl.push_back('{1'b1, 32'd546, 24'd50, 2, 168, 152, 1, 1});

        reset = 1'b1; enable = 1'b0; vsync = 1'b0; x_center = 32'd512; radius = 24'd0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset state", int'(state), 0);
        chk("reset pwm", int'({left_pwm, right_pwm}), 0);
        chk("reset dir", int'({left_dir, right_dir}), 0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_frame(tbl[i].en, tbl[i].x, tbl[i].r, st, lc, rc, ld, rd);
            model_frame(tbl[i].en, tbl[i].x, tbl[i].r);
            check_frame($sformatf("vec%0d", i), st, lc, rc, ld, rd, tbl[i].st,
                        tbl[i].l_duty, tbl[i].r_duty, tbl[i].l_dir, tbl[i].r_dir);
        end

        // Enable drop while both channels are driving high
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(posedge clk); #1;
            if (left_pwm && right_pwm) found = 1'b1;
        end
        chk("pre_drop both_high", int'(found), 1);
        #2 enable = 1'b0;
        @(posedge clk); #1;
        chk("drop left_pwm", int'(left_pwm), 0);
        chk("drop right_pwm", int'(right_pwm), 0);
        chk("drop state", int'(state), 0);
        m_st = 0;
        repeat (300) @(posedge clk);
        #1 chk("drop stays_idle", int'(state), 0);

        // Random frames against the model
        for (int n = 0; n < 40; n++) begin
            en = ($urandom_range(0, 9) != 0);
            case ($urandom_range(0, 5))
                0: r = 24'd0;
                1: r = 24'($urandom_range(3, 4));
                2: r = 24'($urandom_range(5, 119));
                3: r = 24'($urandom_range(100, 140));
                4: r = 24'($urandom);
                default: r = 24'($urandom_range(4, 60));
            endcase
            x = ($urandom_range(0, 7) == 0) ? 32'($urandom) : 32'($urandom_range(0, 1023));
            run_frame(en, x, r, st, lc, rc, ld, rd);
            model_frame(en, x, r);
            model_duty(el, er, eld, erd);
            check_frame($sformatf("rnd%0d", n), st, lc, rc, ld, rd, m_st, el, er, eld, erd);
        end

        // Reset in the middle of a frame pipeline: outputs drop without a clock
        run_frame(1'b1, 32'd700, 24'd0, st, lc, rc, ld, rd);
        model_frame(1'b1, 32'd700, 24'd0);
        chk("pre_reset state", st, m_st);
        @(posedge clk); #1 vsync = 1'b1;
        repeat (2) @(posedge clk);
        #1 vsync = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_reset state", int'(state), 0);
        chk("async_reset pwm", int'({left_pwm, right_pwm}), 0);
        chk("async_reset dir", int'({left_dir, right_dir}), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        repeat (4) @(posedge clk);
        #1 chk("post_reset idle", int'(state), 0);
        run_frame(1'b1, 32'd512, 24'd0, st, lc, rc, ld, rd);
        model_frame(1'b1, 32'd512, 24'd0);
        model_duty(el, er, eld, erd);
        check_frame("post_reset", st, lc, rc, ld, rd, m_st, el, er, eld, erd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
